// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state encoding and register mode constants for the shift sequencer
// Contents:
//   state_e    - controller states (PARITY is only reachable when SHIFT_SEQ_PARITY_EN is defined)
//   MODE_*     - {SH,L} encodings for the external parallel-load shift register
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    PARITY = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;

endpackage

// File: rtl/shift_seq_counter.sv
// shift_seq_counter: frame bit counter with clear, increment and last-bit flag
// Ports:
//   CLK, RST_N - clock, asynchronous active-low reset
//   clr_i      - restart the count at zero (takes priority over inc_i)
//   inc_i      - advance by one accepted bit
//   last_o     - count has reached WIDTH-1 (the final data bit is on offer)
module shift_seq_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb count_d = clr_i ? '0 : inc_i ? count_q + CW'(1) : count_q;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) count_q <= '0;
    else count_q <= count_d;

  assign last_o = count_q == CW'(WIDTH - 1);

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a parallel-load shift register to serialise words LSB-first
// Optional feature: define SHIFT_SEQ_PARITY_EN to append an even-parity bit to every frame.
// Ports:
//   CLK, RST_N           - clock (controller on posedge, register samples on negedge), async active-low reset
//   IN_VALID/IN_READY    - word handshake from the producer, IN_DATA is the word
//   D                    - held copy of the accepted word, wired to the register D inputs
//   SH, L, SI            - register mode selects and serial input
//   Q0                   - register serial output (LSB)
//   BIT_VALID/BIT_READY  - bit handshake to the consumer, SER_BIT is the bit, BIT_LAST marks the frame end
//   BUSY                 - a frame is in progress
//   DONE                 - one-cycle pulse in the first idle cycle after a frame
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter logic        SI_FILL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] D,
  output logic             SH,
  output logic             L,
  output logic             SI,
  input  logic             Q0,
  output logic             BIT_VALID,
  input  logic             BIT_READY,
  output logic             SER_BIT,
  output logic             BIT_LAST,
  output logic             BUSY,
  output logic             DONE
);

`ifdef SHIFT_SEQ_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = IDLE;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             done_q, done_d;
  logic             ser_q;
  logic             accept, bit_hs, last, in_shift;
  logic [1:0]       mode;

  assign in_shift = state_q == SHIFT;
  assign accept   = IN_VALID && IN_READY;
  assign bit_hs   = BIT_VALID && BIT_READY;

  // The register shifts on the negedge inside the handshake cycle, so the
  // next bit is already on Q0 by the posedge that completes the handshake.
  assign mode    = state_q == LOAD ? MODE_LOAD : (in_shift && BIT_READY) ? MODE_SHIFT : MODE_HOLD;
  assign {SH, L} = mode;
  assign SI      = SI_FILL;

  shift_seq_counter #(.WIDTH(WIDTH)) u_counter (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clr_i  (accept),
    .inc_i  (in_shift && bit_hs),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? LOAD : IDLE;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = (bit_hs && last) ? AFTER_DATA : SHIFT;
      default: state_d = bit_hs ? IDLE : PARITY;
    endcase
  end

  assign d_d    = accept ? IN_DATA : d_q;
  assign done_d = bit_hs && BIT_LAST;

  // ser_q samples Q0 at each posedge, giving the consumer a bit that stays
  // stable for the whole cycle even though Q0 moves at the negedge.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      d_q     <= '0;
      done_q  <= 1'b0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      done_q  <= done_d;
      ser_q   <= Q0;
    end

`ifdef SHIFT_SEQ_PARITY_EN
  logic par_q;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) par_q <= 1'b0;
    else par_q <= accept ? ^IN_DATA : par_q;

  assign BIT_VALID = in_shift || state_q == PARITY;
  assign BIT_LAST  = state_q == PARITY;
  assign SER_BIT   = state_q == PARITY ? par_q : ser_q;
`else
  assign BIT_VALID = in_shift;
  assign BIT_LAST  = in_shift && last;
  assign SER_BIT   = ser_q;
`endif

  assign IN_READY = state_q == IDLE;
  assign BUSY     = state_q != IDLE;
  assign D        = d_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for the shift sequencer driving a 4-bit parallel-load shift register
module tb_shift_seq_ctrl;

  localparam int W = 4;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         CLK = 1'b0, RST_N = 1'b0, IN_VALID = 1'b0, BIT_READY = 1'b0;
  logic [W-1:0] IN_DATA = '0;
  logic         IN_READY, SH, L, SI, Q0, BIT_VALID, SER_BIT, BIT_LAST, BUSY, DONE;
  logic [W-1:0] D;
  logic [W-1:0] reg_q = '0;

  int n_chk = 0, n_pass = 0, hs_cnt = 0, cyc = 0, done_cyc = 0;
  logic [1:0] exp_q[$];
  logic done_pend = 1'b0;

  shift_seq_ctrl #(.WIDTH(W), .SI_FILL(1'b0)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .D(D), .SH(SH), .L(L), .SI(SI), .Q0(Q0), .BIT_VALID(BIT_VALID), .BIT_READY(BIT_READY),
    .SER_BIT(SER_BIT), .BIT_LAST(BIT_LAST), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK)
    if (SH) reg_q <= {SI, reg_q[W-1:1]};
    else if (L) reg_q <= D;
  assign Q0 = reg_q[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge CLK) begin
    logic [1:0] e;
    if (!RST_N) done_pend = 1'b0;
    else begin
      if (DONE || done_pend) begin
        check("done_pulse", DONE, done_pend);
        if (DONE) done_cyc = cyc;
      end
      done_pend = 1'b0;
      if (BIT_VALID && BIT_READY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_bit: got bit %b with empty scoreboard at cycle %0d", SER_BIT, cyc);
        end else begin
          e = exp_q.pop_front();
          check("bit_last", {SER_BIT, BIT_LAST}, e);
          done_pend = e[0];
        end
        hs_cnt++;
      end else if (BIT_VALID && exp_q.size() > 0) begin
        check("hold_bit", SER_BIT, exp_q[0][1]);
        check("hold_mode", {SH, L}, 2'b00);
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) exp_q.push_back({w[i], 1'(NB == W && i == W - 1)});
    if (NB > W) exp_q.push_back({^w, 1'b1});
  endtask

  task automatic send(input logic [W-1:0] w, input bit keep, output int acc);
    push_word(w);
    IN_DATA  = w;
    IN_VALID = 1'b1;
    for (int t = 0; t < 50 && !IN_READY; t++) begin
      @(posedge CLK);
      #1;
    end
    if (!IN_READY) check("accept_timeout", IN_READY, 1);
    @(posedge CLK);
    #1;
    acc = cyc;
    if (!keep) IN_VALID = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    for (int t = 0; t < 100 && hs_cnt < target; t++) @(posedge CLK);
    #1;
    check("hs_reached", hs_cnt >= target, 1);
  endtask

  initial begin
    int acc, base;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_mode", {SH, L}, 2'b00);
    check("rst_done", DONE, 0);
    check("rst_bit_valid", BIT_VALID, 0);
    check("rst_d", D, 0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_in_ready", IN_READY, 1);

    // single frame 1011 -> 1,1,0,1
    BIT_READY = 1'b1;
    base = hs_cnt;
    send(4'b1011, 1'b0, acc);
    check("load_mode", {SH, L}, 2'b01);
    check("load_no_bit", BIT_VALID, 0);
    check("load_d", D, 4'b1011);
    check("load_in_ready", IN_READY, 0);
    @(posedge CLK);
    #1;
    check("first_bit_valid", BIT_VALID, 1);
    check("first_bit", SER_BIT, 1);
    wait_hs(base + NB);
    check("single_done", DONE, 1);
    check("single_in_ready", IN_READY, 1);
    @(negedge CLK);
    #1;
    check("frame_cycles", done_cyc - acc, NB + 1);
    @(posedge CLK);
    #1;
    check("done_one_cycle", DONE, 0);

    // backpressure 0110: stall 3 cycles before bit 2
    base = hs_cnt;
    send(4'b0110, 1'b0, acc);
    wait_hs(base + 1);
    BIT_READY = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      check("stall_sh", SH, 0);
      check("stall_bit", SER_BIT, 1);
    end
    BIT_READY = 1'b1;
    wait_hs(base + NB);
    check("bp_done", DONE, 1);
    @(posedge CLK);
    #1;

    // back-to-back 1111 then 0001 with IN_VALID held
    base = hs_cnt;
    send(4'b1111, 1'b1, acc);
    IN_DATA = 4'b0001;
    push_word(4'b0001);
    for (int t = 0; t < 50 && !IN_READY; t++) begin
      @(posedge CLK);
      #1;
    end
    check("b2b_ready_in_done", DONE, 1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    check("b2b_second_load", {SH, L}, 2'b01);
    check("b2b_second_d", D, 4'b0001);
    wait_hs(base + 2 * NB);
    check("b2b_done", DONE, 1);
    @(posedge CLK);
    #1;

    // reset mid-frame after bit 2 of 1010
    base = hs_cnt;
    send(4'b1010, 1'b0, acc);
    wait_hs(base + 2);
    RST_N = 1'b0;
    BIT_READY = 1'b0;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_bit_valid", BIT_VALID, 0);
    exp_q.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (2) begin
      @(posedge CLK);
      #1;
      check("abort_no_done", DONE, 0);
    end
    check("abort_in_ready", IN_READY, 1);
    BIT_READY = 1'b1;
    base = hs_cnt;
    send(4'b0011, 1'b0, acc);
    wait_hs(base + NB);
    check("after_abort_done", DONE, 1);
    @(posedge CLK);
    #1;

`ifdef SHIFT_SEQ_PARITY_EN
    base = hs_cnt;
    send(4'b0111, 1'b0, acc);
    wait_hs(base + NB);
    check("parity_done", DONE, 1);
    @(posedge CLK);
    #1;
`endif

    repeat (2) @(posedge CLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
